// File: rtl/enc_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : enc_sched_pkg
// Purpose  : Shared types and constants for the encoder lane scheduler:
//            FSM state enum, d_sel codes, gen-speed codes, block length.
// Revision : 1.0 - initial release
// ============================================================================
package enc_sched_pkg;

  // Which source owns the block currently being emitted
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OS_BLK = 2'd1,
    TL_BLK = 2'd2
  } sched_state_e;

  // d_sel codes: ordered sets use their own code 0..7
  localparam logic [3:0] DSEL_TL_DEF   = 4'd8;
  localparam logic [3:0] DSEL_IDLE_DEF = 4'd9;

  // gen_speed_cfg encodings
  localparam logic [1:0] GEN4     = 2'd0;
  localparam logic [1:0] GEN3     = 2'd1;
  localparam logic [1:0] GEN2     = 2'd2;
  localparam logic [1:0] GEN_RSVD = 2'd3;

  localparam int CNT_W = 4;  // byte_idx width, covers 0..15
  localparam int LEN_W = 5;  // block length width, covers 16

  // Bytes per block for a given speed; reserved speed yields 0 (never granted)
  function automatic logic [LEN_W-1:0] blk_len(input logic [1:0] speed);
    logic [LEN_W-1:0] len;
    case (speed)
      GEN4:    len = 5'd1;
      GEN3:    len = 5'd16;
      GEN2:    len = 5'd8;
      default: len = 5'd0;
    endcase
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/enc_sym_counter.sv
`default_nettype none
// ============================================================================
// Module   : enc_sym_counter
// Purpose  : Byte position counter inside a block. Tracks the index of the
//            next byte to take, detects the wrap at L-1 and registers the
//            byte_idx / sym_start outputs that accompany each emitted byte.
// Revision : 1.0 - initial release
// ============================================================================
module enc_sym_counter
  import enc_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  input  logic [LEN_W-1:0] len,
  output logic             at_zero,
  output logic [CNT_W-1:0] byte_idx,
  output logic             sym_start
);

  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] byte_idx_q, byte_idx_d;
  logic             sym_start_q, sym_start_d;
  logic             wrap;

  assign at_zero = (idx_q == '0);
  assign wrap    = ({1'b0, idx_q} == (len - LEN_W'(1)));

  // Next index and the per-byte position tags for the byte taken this cycle
  always_comb begin
    idx_d       = idx_q;
    byte_idx_d  = '0;
    sym_start_d = 1'b0;
    if (clr) begin
      idx_d = '0;
    end else if (adv) begin
      idx_d       = wrap ? '0 : idx_q + CNT_W'(1);
      byte_idx_d  = idx_q;
      sym_start_d = at_zero;
    end
  end

  // Counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      byte_idx_q  <= '0;
      sym_start_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      byte_idx_q  <= byte_idx_d;
      sym_start_q <= sym_start_d;
    end
  end

  assign byte_idx  = byte_idx_q;
  assign sym_start = sym_start_q;

endmodule
`default_nettype wire

// File: rtl/enc_lane_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : enc_lane_scheduler
// Purpose  : Grants fixed-length blocks to either the ordered-set source or
//            the transport-layer source and serialises their bytes onto two
//            lanes with a 1-cycle registered output stage.
//            Build option: ENC_SCHED_RR_EN selects round-robin arbitration
//            between the two sources; otherwise OS has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module enc_lane_scheduler
  import enc_sched_pkg::*;
#(
  parameter logic [3:0] IDLE_DSEL = DSEL_IDLE_DEF,
  parameter logic [3:0] TL_DSEL   = DSEL_TL_DEF
) (
  input  logic       enc_clk,
  input  logic       rst,
  input  logic       sched_en,
  input  logic [1:0] gen_speed_cfg,
  input  logic       os_req,
  input  logic [3:0] os_sel,
  input  logic [7:0] os_lane_0,
  input  logic [7:0] os_lane_1,
  output logic       os_ack,
  input  logic       tl_valid,
  input  logic [7:0] tl_lane_0,
  input  logic [7:0] tl_lane_1,
  output logic       tl_ack,
  output logic [7:0] lane_0_tx,
  output logic [7:0] lane_1_tx,
  output logic [3:0] d_sel,
  output logic [1:0] gen_speed,
  output logic       enable,
  output logic       sym_start,
  output logic [3:0] byte_idx,
  output logic       tl_underrun
);

  sched_state_e     state_q, state_d, src, both_pick;
  logic [7:0]       lane_0_q, lane_0_d, lane_1_q, lane_1_d;
  logic [3:0]       d_sel_q, d_sel_d;
  logic [1:0]       gen_speed_q, gen_speed_d;
  logic             enable_q, enable_d;
  logic             underrun_q, underrun_d;
  logic             at_zero, take;
  logic [LEN_W-1:0] len_sel;

`ifdef ENC_SCHED_RR_EN
  logic last_tl_q, last_tl_d;

  // Remember which source won the most recent block grant
  always_comb begin
    last_tl_d = last_tl_q;
    if (take && at_zero) last_tl_d = (src == TL_BLK);
  end

  // Reset as if TL won last so OS goes first after reset
  always_ff @(posedge enc_clk or negedge rst) begin
    if (!rst) last_tl_q <= 1'b1;
    else      last_tl_q <= last_tl_d;
  end

  assign both_pick = last_tl_q ? OS_BLK : TL_BLK;
`else
  assign both_pick = OS_BLK;
`endif

  // Source selection: arbitrate at a block boundary, otherwise stay with the
  // block in progress. Gating with rst keeps the acks low while in reset.
  always_comb begin
    src = IDLE;
    if (rst && sched_en) begin
      if (at_zero) begin
        if (gen_speed_cfg != GEN_RSVD) begin
          if (os_req && tl_valid) src = both_pick;
          else if (os_req)        src = OS_BLK;
          else if (tl_valid)      src = TL_BLK;
        end
      end else begin
        src = state_q;
      end
    end
  end

  assign take    = (src != IDLE);
  assign len_sel = at_zero ? blk_len(gen_speed_cfg) : blk_len(gen_speed_q);
  assign os_ack  = (src == OS_BLK) && os_req;
  assign tl_ack  = (src == TL_BLK) && tl_valid;

  // Next-state and registered-output values for the byte taken this cycle
  always_comb begin
    state_d     = src;
    lane_0_d    = 8'h00;
    lane_1_d    = 8'h00;
    enable_d    = take;
    gen_speed_d = gen_speed_q;
    d_sel_d     = IDLE_DSEL;
    underrun_d  = underrun_q;
    if (src == OS_BLK) begin
      lane_0_d = os_lane_0;
      lane_1_d = os_lane_1;
    end else if (src == TL_BLK && tl_valid) begin
      lane_0_d = tl_lane_0;
      lane_1_d = tl_lane_1;
    end
    if (take) begin
      if (at_zero) begin
        gen_speed_d = gen_speed_cfg;
        d_sel_d     = (src == OS_BLK) ? os_sel : TL_DSEL;
      end else begin
        d_sel_d = d_sel_q;
      end
    end
    if (!sched_en)                        underrun_d = 1'b0;
    else if (src == TL_BLK && !tl_valid)  underrun_d = 1'b1;
  end

  // Scheduler FSM with registered lane outputs
  always_ff @(posedge enc_clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      lane_0_q    <= 8'h00;
      lane_1_q    <= 8'h00;
      d_sel_q     <= IDLE_DSEL;
      gen_speed_q <= GEN4;
      enable_q    <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_0_q    <= lane_0_d;
      lane_1_q    <= lane_1_d;
      d_sel_q     <= d_sel_d;
      gen_speed_q <= gen_speed_d;
      enable_q    <= enable_d;
      underrun_q  <= underrun_d;
    end
  end

  enc_sym_counter u_cnt (
    .clk       (enc_clk),
    .rst_n     (rst),
    .clr       (~sched_en),
    .adv       (take),
    .len       (len_sel),
    .at_zero   (at_zero),
    .byte_idx  (byte_idx),
    .sym_start (sym_start)
  );

  assign lane_0_tx   = lane_0_q;
  assign lane_1_tx   = lane_1_q;
  assign d_sel       = d_sel_q;
  assign gen_speed   = gen_speed_q;
  assign enable      = enable_q;
  assign tl_underrun = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_enc_lane_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_enc_lane_scheduler
// Purpose  : Self-checking bench for enc_lane_scheduler. Expected output
//            bytes are queued when stimulus is applied and compared one
//            clock later when the registered outputs appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enc_lane_scheduler;

  logic       enc_clk = 1'b0;
  logic       rst = 1'b0;
  logic       sched_en = 1'b0;
  logic [1:0] gen_speed_cfg = 2'd0;
  logic       os_req = 1'b0;
  logic [3:0] os_sel = 4'd0;
  logic [7:0] os_lane_0 = 8'h00, os_lane_1 = 8'h00;
  logic       tl_valid = 1'b0;
  logic [7:0] tl_lane_0 = 8'h00, tl_lane_1 = 8'h00;
  logic       os_ack, tl_ack;
  logic [7:0] lane_0_tx, lane_1_tx;
  logic [3:0] d_sel, byte_idx;
  logic [1:0] gen_speed;
  logic       enable, sym_start, tl_underrun;

  int checks = 0;
  int failures = 0;
  logic [25:0] sb[$];
  logic [25:0] e;

`ifdef ENC_SCHED_RR_EN
  bit rr = 1'b1;
`else
  bit rr = 1'b0;
`endif

  enc_lane_scheduler dut (
    .enc_clk(enc_clk), .rst(rst), .sched_en(sched_en), .gen_speed_cfg(gen_speed_cfg),
    .os_req(os_req), .os_sel(os_sel), .os_lane_0(os_lane_0), .os_lane_1(os_lane_1),
    .os_ack(os_ack), .tl_valid(tl_valid), .tl_lane_0(tl_lane_0), .tl_lane_1(tl_lane_1),
    .tl_ack(tl_ack), .lane_0_tx(lane_0_tx), .lane_1_tx(lane_1_tx), .d_sel(d_sel),
    .gen_speed(gen_speed), .enable(enable), .sym_start(sym_start), .byte_idx(byte_idx),
    .tl_underrun(tl_underrun)
  );

  always #5 enc_clk = ~enc_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [25:0] mk(input logic [7:0] l0, input logic [7:0] l1,
                                     input logic [3:0] ds, input logic [3:0] ix,
                                     input logic sy, input logic en);
    return {l0, l1, ds, ix, sy, en};
  endfunction

  function automatic logic [25:0] obs();
    return {lane_0_tx, lane_1_tx, d_sel, byte_idx, sym_start, enable};
  endfunction

  task automatic set_in(input logic sen, input logic [1:0] cfg, input logic osr,
                        input logic [3:0] oss, input logic [7:0] o0, input logic [7:0] o1,
                        input logic tlv, input logic [7:0] t0, input logic [7:0] t1);
    sched_en = sen; gen_speed_cfg = cfg; os_req = osr; os_sel = oss;
    os_lane_0 = o0; os_lane_1 = o1; tl_valid = tlv; tl_lane_0 = t0; tl_lane_1 = t1;
  endtask

  task automatic tick();
    @(posedge enc_clk);
    #1;
  endtask

  task automatic idle_gap();
    @(negedge enc_clk);
    set_in(1'b0, 2'd0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    tick();
  endtask

  task automatic test_reset();
    set_in(1'b1, 2'd1, 1'b1, 4'd2, 8'h11, 8'h22, 1'b1, 8'h33, 8'h44);
    repeat (3) @(posedge enc_clk);
    @(negedge enc_clk);
    #1;
    checks++;
    if (obs() !== mk(8'h00, 8'h00, 4'd9, 4'd0, 1'b0, 1'b0)) begin
      failures++; $display("FAIL reset_outputs got=%h exp=%h", obs(), mk(8'h00, 8'h00, 4'd9, 4'd0, 1'b0, 1'b0));
    end
    checks++;
    if ({os_ack, tl_ack, tl_underrun, gen_speed} !== 5'b0) begin
      failures++; $display("FAIL reset_misc got os_ack=%b tl_ack=%b ur=%b gs=%0d exp all 0", os_ack, tl_ack, tl_underrun, gen_speed);
    end
    set_in(1'b0, 2'd0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    tick();
  endtask

  // gen3 TL stream: two back-to-back 16-byte blocks
  task automatic test_gen3_tl();
    int acks = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge enc_clk);
      set_in(1'b1, 2'd1, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 8'(k), 8'(~k));
      #1;
      checks++;
      if (tl_ack !== 1'b1 || os_ack !== 1'b0) begin
        failures++; $display("FAIL gen3_ack k=%0d got os=%b tl=%b exp os=0 tl=1", k, os_ack, tl_ack);
      end
      if (tl_ack === 1'b1) acks++;
      sb.push_back(mk(8'(k), 8'(~k), 4'd8, 4'(k % 16), (k % 16) == 0, 1'b1));
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++; $display("FAIL gen3_out k=%0d got=%h exp=%h", k, obs(), e);
      end
      if (k % 16 == 15) begin
        checks++;
        if (acks !== 16 || gen_speed !== 2'd1) begin
          failures++; $display("FAIL gen3_block got acks=%0d gs=%0d exp acks=16 gs=1", acks, gen_speed);
        end
        acks = 0;
      end
    end
    idle_gap();
  endtask

  // gen2 OS block wins over TL, holds d_sel and length, then TL follows
  task automatic test_gen2_os_first();
    for (int k = 0; k < 16; k++) begin
      logic is_os;
      is_os = (k < 8);
      @(negedge enc_clk);
      set_in(1'b1, (k >= 3 && k <= 6) ? 2'd1 : 2'd2, is_os, (k >= 3) ? 4'd5 : 4'd3,
             8'(8'hA0 + k), 8'(8'h50 + k), 1'b1, 8'(8'hC0 + k), 8'(8'hD0 + k));
      #1;
      checks++;
      if (os_ack !== is_os || tl_ack !== !is_os) begin
        failures++; $display("FAIL gen2_ack k=%0d got os=%b tl=%b exp os=%b tl=%b", k, os_ack, tl_ack, is_os, !is_os);
      end
      if (is_os) sb.push_back(mk(8'(8'hA0 + k), 8'(8'h50 + k), 4'd3, 4'(k), k == 0, 1'b1));
      else       sb.push_back(mk(8'(8'hC0 + k), 8'(8'hD0 + k), 4'd8, 4'(k - 8), k == 8, 1'b1));
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e || gen_speed !== 2'd2) begin
        failures++; $display("FAIL gen2_out k=%0d got=%h gs=%0d exp=%h gs=2", k, obs(), gen_speed, e);
      end
    end
    idle_gap();
  endtask

  // TL data runs dry at byte 5 of a gen3 block
  task automatic test_underrun();
    for (int k = 0; k < 17; k++) begin
      logic v;
      v = (k < 5);
      @(negedge enc_clk);
      set_in(1'b1, 2'd1, 1'b0, 4'd0, 8'h00, 8'h00, v, v ? 8'(8'h30 + k) : 8'hEE, 8'hEE);
      #1;
      checks++;
      if (tl_ack !== v || os_ack !== 1'b0) begin
        failures++; $display("FAIL underrun_ack k=%0d got tl=%b exp tl=%b", k, tl_ack, v);
      end
      if (k == 16) sb.push_back(mk(8'h00, 8'h00, 4'd9, 4'd0, 1'b0, 1'b0));
      else sb.push_back(mk(v ? 8'(8'h30 + k) : 8'h00, v ? 8'hEE : 8'h00, 4'd8, 4'(k), k == 0, 1'b1));
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e || tl_underrun !== (k >= 5)) begin
        failures++; $display("FAIL underrun_out k=%0d got=%h ur=%b exp=%h ur=%b", k, obs(), tl_underrun, e, k >= 5);
      end
    end
    idle_gap();
    checks++;
    if (tl_underrun !== 1'b0) begin
      failures++; $display("FAIL underrun_clear got=%b exp=0", tl_underrun);
    end
  endtask

  // sched_en dropped while byte 9 is on the lanes
  task automatic test_abort();
    for (int k = 0; k < 12; k++) begin
      logic sen;
      sen = (k != 10);
      @(negedge enc_clk);
      set_in(sen, 2'd1, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 8'(8'h60 + k), 8'(8'h70 + k));
      #1;
      checks++;
      if (tl_ack !== sen) begin
        failures++; $display("FAIL abort_ack k=%0d got tl=%b exp tl=%b", k, tl_ack, sen);
      end
      if (k == 10)      sb.push_back(mk(8'h00, 8'h00, 4'd9, 4'd0, 1'b0, 1'b0));
      else if (k == 11) sb.push_back(mk(8'h6B, 8'h7B, 4'd8, 4'd0, 1'b1, 1'b1));
      else              sb.push_back(mk(8'(8'h60 + k), 8'(8'h70 + k), 4'd8, 4'(k), k == 0, 1'b1));
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++; $display("FAIL abort_out k=%0d got=%h exp=%h", k, obs(), e);
      end
    end
    idle_gap();
  endtask

  // Both sources requesting for four gen2 blocks
  task automatic test_arbitration();
    for (int k = 0; k < 32; k++) begin
      logic g_os;
      g_os = rr ? ((k / 8) % 2 == 0) : 1'b1;
      @(negedge enc_clk);
      set_in(1'b1, 2'd2, 1'b1, 4'd6, 8'(8'h10 + k), 8'(8'h20 + k), 1'b1, 8'(8'h80 + k), 8'(8'h90 + k));
      #1;
      checks++;
      if (os_ack !== g_os || tl_ack !== !g_os) begin
        failures++; $display("FAIL arb_ack k=%0d got os=%b tl=%b exp os=%b tl=%b", k, os_ack, tl_ack, g_os, !g_os);
      end
      if (g_os) sb.push_back(mk(8'(8'h10 + k), 8'(8'h20 + k), 4'd6, 4'(k % 8), k % 8 == 0, 1'b1));
      else      sb.push_back(mk(8'(8'h80 + k), 8'(8'h90 + k), 4'd8, 4'(k % 8), k % 8 == 0, 1'b1));
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++; $display("FAIL arb_out k=%0d got=%h exp=%h", k, obs(), e);
      end
    end
    idle_gap();
  endtask

  // gen4 one-byte blocks, then reserved speed keeps the scheduler idle
  task automatic test_gen4_and_reserved();
    for (int k = 0; k < 6; k++) begin
      logic rsv;
      rsv = (k >= 4);
      @(negedge enc_clk);
      set_in(1'b1, rsv ? 2'd3 : 2'd0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 8'(8'hE0 + k), 8'(8'hF0 + k));
      #1;
      checks++;
      if (tl_ack !== !rsv) begin
        failures++; $display("FAIL gen4_ack k=%0d got tl=%b exp tl=%b", k, tl_ack, !rsv);
      end
      if (rsv) sb.push_back(mk(8'h00, 8'h00, 4'd9, 4'd0, 1'b0, 1'b0));
      else     sb.push_back(mk(8'(8'hE0 + k), 8'(8'hF0 + k), 4'd8, 4'd0, 1'b1, 1'b1));
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++; $display("FAIL gen4_out k=%0d got=%h exp=%h", k, obs(), e);
      end
    end
    idle_gap();
  endtask

  // Reset asserted between clock edges in the middle of a gen3 block
  task automatic test_async_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge enc_clk);
      set_in(1'b1, 2'd1, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 8'(8'h40 + k), 8'h5A);
      sb.push_back(mk(8'(8'h40 + k), 8'h5A, 4'd8, 4'(k), k == 0, 1'b1));
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++; $display("FAIL arst_pre k=%0d got=%h exp=%h", k, obs(), e);
      end
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (obs() !== mk(8'h00, 8'h00, 4'd9, 4'd0, 1'b0, 1'b0)) begin
      failures++; $display("FAIL arst_outputs got=%h exp=%h", obs(), mk(8'h00, 8'h00, 4'd9, 4'd0, 1'b0, 1'b0));
    end
    checks++;
    if ({os_ack, tl_ack, tl_underrun, gen_speed} !== 5'b0) begin
      failures++; $display("FAIL arst_misc got os=%b tl=%b ur=%b gs=%0d exp all 0", os_ack, tl_ack, tl_underrun, gen_speed);
    end
    @(negedge enc_clk);
    rst = 1'b1;
    set_in(1'b1, 2'd1, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 8'h99, 8'h88);
    sb.push_back(mk(8'h99, 8'h88, 4'd8, 4'd0, 1'b1, 1'b1));
    tick();
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin
      failures++; $display("FAIL arst_restart got=%h exp=%h", obs(), e);
    end
    idle_gap();
  endtask

  initial begin
    test_reset();
    test_gen3_tl();
    test_gen2_os_first();
    test_underrun();
    test_abort();
    test_arbitration();
    test_gen4_and_reserved();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/enc_lane_scheduler.md
ENC_LANE_SCHEDULER -- requirements
Module: enc_lane_scheduler

Interface
REQ-001 SHALL have parameter IDLE_DSEL, default 4'd9: d_sel code driven when no block is granted.
REQ-002 SHALL have parameter TL_DSEL, default 4'd8: d_sel code for transport-layer blocks.
REQ-003 SHALL have port enc_clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port sched_en, input, 1: scheduler enable; low aborts the current block.
REQ-006 SHALL have port gen_speed_cfg, input, 2: link speed: 0 gen4 (1-byte block), 1 gen3 (16-byte block), 2 gen2 (8-byte block), 3 reserved.
REQ-007 SHALL have ports os_req (input, 1), os_sel (input, 4, ordered-set code 0..7), os_lane_0/os_lane_1 (input, 8 each) and os_ack (output, 1, byte consumed).
REQ-008 SHALL have ports tl_valid (input, 1), tl_lane_0/tl_lane_1 (input, 8 each) and tl_ack (output, 1, byte consumed).
REQ-009 SHALL have outputs lane_0_tx and lane_1_tx (8 each), d_sel (4), gen_speed (2), enable (1), sym_start (1, first byte of block) and byte_idx (4).
REQ-010 SHALL have output tl_underrun, 1: sticky flag, set when transport data runs dry mid-block.

Function
REQ-011 SHALL use block length L = 1, 16 or 8 for gen_speed_cfg 0, 1 or 2; gen_speed_cfg 3 SHALL hold the FSM in IDLE.
REQ-012 SHALL implement FSM states IDLE, OS_BLK and TL_BLK.
REQ-013 SHALL take the grant decision only when byte_idx==0, i.e. at a block boundary.
REQ-014 SHALL, from IDLE with sched_en=1, go to OS_BLK if os_req, else to TL_BLK if tl_valid, else stay in IDLE.
REQ-015 SHALL, in OS_BLK or TL_BLK, count byte_idx 0..L-1; at L-1 it SHALL wrap to 0 and re-arbitrate in the same cycle (back-to-back blocks, no bubble).
REQ-016 SHALL latch gen_speed_cfg into gen_speed and the block d_sel at the block boundary only; mid-block changes on gen_speed_cfg SHALL be ignored.
REQ-017 SHALL hold d_sel constant for the whole block: os_sel for OS_BLK, TL_DSEL for TL_BLK, IDLE_DSEL in IDLE.
REQ-018 SHALL assert os_ack or tl_ack combinationally for each cycle its byte is taken; lane_0_tx/lane_1_tx SHALL be registered (1-cycle latency from ack), with enable=1 alongside.
REQ-019 SHALL NOT assert os_ack and tl_ack in the same cycle.
REQ-020 SHALL, when tl_valid=0 inside TL_BLK, output 8'h00 on both lanes, keep counting, deassert tl_ack, and set tl_underrun.
REQ-021 SHALL require os_req to hold for a whole OS block; if it drops, the block SHALL finish with the held os_lane data.
REQ-022 SHALL assert sym_start in the cycle the byte at byte_idx 0 is output; for L=1 it SHALL be high on every output byte.
REQ-023 SHALL, when sched_en goes low, drop to IDLE in the next cycle, zero byte_idx and lanes, drive enable=0 and d_sel=IDLE_DSEL, and discard the partial block.
REQ-024 SHALL keep tl_underrun set until reset or until sched_en goes low.

Reset
REQ-025 SHALL, on rst=0 (asynchronous), clear state to IDLE and drive lanes 0, d_sel IDLE_DSEL, gen_speed 0, enable 0, byte_idx 0, sym_start 0, acks 0 and tl_underrun 0.
REQ-026 SHALL apply reset mid-block immediately; no partial block SHALL resume after reset is released.

Configuration
REQ-027 SHALL, with ENC_SCHED_RR_EN defined, arbitrate round-robin: when os_req and tl_valid are both high at a boundary, the grant goes to the requester not granted last.
REQ-028 SHALL, without ENC_SCHED_RR_EN, use fixed priority with OS ahead of TL.

Structure
REQ-029 SHALL place the FSM state enum, d_sel codes, gen-speed codes and the block-length function in package enc_sched_pkg.
REQ-030 SHALL use sub-module enc_sym_counter for byte_idx, wrap detection and sym_start.

Verification
REQ-031 SHALL cover: gen_speed_cfg=1, tl_valid held -> d_sel=8 constant, sym_start every 16 cycles, 16 tl_ack per block.
REQ-032 SHALL cover: gen_speed_cfg=2, os_req with os_sel=3 plus tl_valid -> 8-byte OS block (d_sel=3) first, and no switch before byte_idx 7.
REQ-033 SHALL cover: gen3 TL block, tl_valid dropped at byte 5 -> bytes 5..15 are 8'h00, tl_underrun=1, next boundary goes to IDLE.
REQ-034 SHALL cover: sched_en low at byte 9 -> next cycle enable=0, d_sel=9, byte_idx=0.
REQ-035 SHALL cover: with ENC_SCHED_RR_EN, both requesters high for 4 gen2 blocks -> grants OS, TL, OS, TL; without it -> OS, OS, OS, OS.
REQ-036 SHALL cover: rst asserted mid gen3 block -> all outputs reach their reset values asynchronously.
